mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/cpu_pkg.sv | 6 +
 rtl/mem_arbiter_rr_arb2.sv | 24 ++
 rtl/mem_arbiter.sv | 62 ++++++
 tb/tb_mem_arbiter.sv | 133 +++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths and response-owner encoding for the memory arbiter
package cpu_pkg;
  localparam int ADDR_W = 18;
  localparam int DATA_W = 32;
  typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_e;
endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: 2-way round-robin arbiter between fetch and data requesters
//   clk, n_reset        : clock, async active-low reset
//   i_req_if, i_req_d   : requests
//   o_gnt_if, o_gnt_d   : one-hot (or zero) combinational grants, gated by reset
module rr_arb2
  import cpu_pkg::*;
(
  input  logic clk,
  input  logic n_reset,
  input  logic i_req_if,
  input  logic i_req_d,
  output logic o_gnt_if,
  output logic o_gnt_d
);
  owner_e r_last_gnt;
  logic   w_pick_if;
  // fetch wins when alone, or on a tie when data was served last
  assign w_pick_if = i_req_if & (~i_req_d | (r_last_gnt == OWN_D));
  assign o_gnt_if  = n_reset & w_pick_if;
  assign o_gnt_d   = n_reset & i_req_d & ~w_pick_if;
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) r_last_gnt <= OWN_D;
    else if (o_gnt_if | o_gnt_d) r_last_gnt <= o_gnt_d ? OWN_D : OWN_IF;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one registered-read BRAM port between fetch and data masters
//   fetch side : if_req/if_addr in, if_gnt/if_rvalid out
//   data side  : d_req/d_we/d_addr/d_wdata in, d_gnt/d_rvalid out
//   rdata      : shared read-return bus (mem_rdata passthrough)
//   BRAM side  : mem_en/mem_we/mem_addr/mem_wdata out, mem_rdata in
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DATA_W = cpu_pkg::DATA_W
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic                if_req,
  input  logic [ADDR_W+1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  input  logic                d_req,
  input  logic [DATA_W/8-1:0] d_we,
  input  logic [ADDR_W+1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);
  logic   w_gnt_if, w_gnt_d, w_rd, w_unused;
  logic   r_rsp_valid;
  owner_e r_rsp_owner;
  rr_arb2 u_arb (
    .clk     (clk),
    .n_reset (n_reset),
    .i_req_if(if_req),
    .i_req_d (d_req),
    .o_gnt_if(w_gnt_if),
    .o_gnt_d (w_gnt_d)
  );
  assign if_gnt    = w_gnt_if;
  assign d_gnt     = w_gnt_d;
  assign mem_en    = w_gnt_if | w_gnt_d;
  assign mem_addr  = w_gnt_d ? d_addr[ADDR_W+1:2] : if_addr[ADDR_W+1:2];
  assign mem_we    = w_gnt_d ? d_we : '0;
  assign mem_wdata = d_wdata;
  assign rdata     = mem_rdata;
  assign w_unused  = ^{if_addr[1:0], d_addr[1:0]};
  // writes retire at grant; only reads expect data back next cycle
  assign w_rd      = w_gnt_if | (w_gnt_d & (d_we == '0));
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_owner <= OWN_IF;
    end else begin
      r_rsp_valid <= w_rd;
      r_rsp_owner <= w_gnt_d ? OWN_D : OWN_IF;
    end
  assign if_rvalid = r_rsp_valid & (r_rsp_owner == OWN_IF);
  assign d_rvalid  = r_rsp_valid & (r_rsp_owner == OWN_D);
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter with a registered-read BRAM model
module tb_mem_arbiter;
  logic        clk = 1'b0, n_reset = 1'b0;
  logic        if_req = 1'b0, d_req = 1'b0;
  logic [19:0] if_addr = '0, d_addr = '0;
  logic [3:0]  d_we = '0;
  logic [31:0] d_wdata = '0;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en;
  logic [31:0] rdata, mem_wdata, mem_rdata = '0;
  logic [3:0]  mem_we;
  logic [17:0] mem_addr;
  logic [31:0] mem [0:262143];
  logic [20:0] wide;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {logic own; logic [31:0] data; int cyc;} exp_t;
  exp_t q[$];

  mem_arbiter dut (
    .clk(clk), .n_reset(n_reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] merge(input logic [31:0] o, n, input logic [3:0] we);
    for (int b = 0; b < 4; b++) if (we[b]) o[b*8+:8] = n[b*8+:8];
    return o;
  endfunction

  always @(posedge clk)
    if (mem_en) begin
      mem_rdata <= mem[mem_addr];
      if (mem_we != 0) mem[mem_addr] <= merge(mem[mem_addr], mem_wdata, mem_we);
    end

  task automatic chk(input string name, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    chk("rvalid_exclusive", {31'b0, if_rvalid & d_rvalid}, 0);
    if (if_rvalid || d_rvalid) begin
      if (q.size() == 0) chk("unexpected_rvalid", {30'b0, if_rvalid, d_rvalid}, 0);
      else begin
        e = q.pop_front();
        chk("rsp_owner", {31'b0, d_rvalid}, {31'b0, e.own});
        chk("rdata", rdata, e.data);
        chk("rsp_cycle", cyc, e.cyc);
      end
    end else if (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      chk("missing_rvalid", {31'b0, if_rvalid | d_rvalid}, 1);
    end
  end

  task automatic step(input logic e_if, e_d, input logic [17:0] e_addr,
                      input logic [3:0] e_we, input logic [31:0] e_data);
    @(negedge clk);
    chk("if_gnt", {31'b0, if_gnt}, {31'b0, e_if});
    chk("d_gnt", {31'b0, d_gnt}, {31'b0, e_d});
    chk("mem_en", {31'b0, mem_en}, {31'b0, e_if | e_d});
    chk("mem_we", {28'b0, mem_we}, {28'b0, e_we});
    if (e_if || e_d) chk("mem_addr", {14'b0, mem_addr}, {14'b0, e_addr});
    if ((e_if || e_d) && e_we == 0) q.push_back('{e_d, e_data, cyc + 1});
    @(posedge clk); #1;
  endtask

  task automatic reset_outputs_zero();
    @(negedge clk);
    chk("rst_if_gnt", {31'b0, if_gnt}, 0);
    chk("rst_d_gnt", {31'b0, d_gnt}, 0);
    chk("rst_mem_en", {31'b0, mem_en}, 0);
    chk("rst_mem_we", {28'b0, mem_we}, 0);
    chk("rst_if_rvalid", {31'b0, if_rvalid}, 0);
    chk("rst_d_rvalid", {31'b0, d_rvalid}, 0);
  endtask

  initial begin
    for (int i = 0; i < 262144; i++) mem[i] = '0;
    mem[0] = 32'h0000_0013; mem[1] = 32'h1111_1111; mem[2] = 32'h2222_2222;
    mem[4] = 32'hE3A0_1005; mem[8] = 32'h1122_3344; mem[18'h3FFFF] = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    #1;
    if_req = 1; d_req = 1; if_addr = 20'h0; d_addr = 20'h10;
    reset_outputs_zero();
    @(posedge clk); #1;
    n_reset = 1;
    step(1, 0, 18'd0, 4'd0, 32'h0000_0013);
    step(0, 1, 18'd4, 4'd0, 32'hE3A0_1005);
    step(1, 0, 18'd0, 4'd0, 32'h0000_0013);
    step(0, 1, 18'd4, 4'd0, 32'hE3A0_1005);
    d_req = 0; if_addr = 20'h10;
    step(1, 0, 18'd4, 4'd0, 32'hE3A0_1005);
    if_addr = 20'h0; step(1, 0, 18'd0, 4'd0, 32'h0000_0013);
    if_addr = 20'h4; step(1, 0, 18'd1, 4'd0, 32'h1111_1111);
    if_addr = 20'h8; step(1, 0, 18'd2, 4'd0, 32'h2222_2222);
    if_req = 0; d_req = 1; d_we = 4'b0011; d_addr = 20'h20; d_wdata = 32'hAABB_CCDD;
    step(0, 1, 18'd8, 4'b0011, 32'h0);
    d_we = 4'b0000;
    step(0, 1, 18'd8, 4'd0, 32'h1122_CCDD);
    d_req = 0;
    step(0, 0, 18'd0, 4'd0, 32'h0);
    if_req = 1; d_req = 1; if_addr = 20'h0; d_addr = 20'h10;
    step(1, 0, 18'd0, 4'd0, 32'h0000_0013);
    step(0, 1, 18'd4, 4'd0, 32'hE3A0_1005);
    d_req = 0; if_addr = 20'hFFFFC;
    step(1, 0, 18'h3FFFF, 4'd0, 32'hDEAD_BEEF);
    wide = 21'h100000; if_addr = wide[19:0];
    step(1, 0, 18'h00000, 4'd0, 32'h0000_0013);
    if_addr = 20'h10;
    step(1, 0, 18'd4, 4'd0, 32'hE3A0_1005);
    n_reset = 0;
    void'(q.pop_back());
    reset_outputs_zero();
    @(posedge clk); #1;
    n_reset = 1; if_req = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
